// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: one shared shift engine, shift-add for
// multiply and restoring subtract for divide, with a single sign-fixup cycle.
module mul_div_unit #(
    parameter int DATAWIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2:0]           op,
    input  logic [DATAWIDTH-1:0] src_a,
    input  logic [DATAWIDTH-1:0] src_b,
    output logic                 busy,
    output logic                 done,
    output logic [DATAWIDTH-1:0] result
);
    localparam int W  = DATAWIDTH;
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {IDLE, CALC, FIXUP} state_t;

    state_t         state, state_next;
    logic [2:0]     op_q;
    logic           neg_q;
    logic [CW-1:0]  cnt;
    logic [2*W-1:0] acc;
    logic [W-1:0]   x_q;   // multiplier (shifts right) or dividend (shifts left)
    logic [W-1:0]   y_q;   // multiplicand or divisor

    logic           is_div, signed_a, signed_b, sign_a, sign_b;
    logic           div_zero, div_ovf, special, neg_in;
    logic [W-1:0]   mag_a, mag_b;
    logic [2*W-1:0] special_acc;

    always_comb begin
        is_div      = op[2];
        signed_a    = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
        signed_b    = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
        sign_a      = signed_a & src_a[W-1];
        sign_b      = signed_b & src_b[W-1];
        mag_a       = sign_a ? -src_a : src_a;
        mag_b       = sign_b ? -src_b : src_b;
        div_zero    = is_div && (src_b == '0);
        div_ovf     = is_div && signed_b && (src_a == {1'b1, {(W-1){1'b0}}}) && (src_b == '1);
        special     = div_zero || div_ovf;
        // Rem takes the dividend's sign; mul and quotient take the XOR
        neg_in      = (is_div && op[1]) ? sign_a : (sign_a ^ sign_b);
        // Special results are preloaded as {rem, quot} so FIXUP selects them unchanged
        special_acc = div_zero ? {src_a, {W{1'b1}}}
                               : {{W{1'b0}}, 1'b1, {(W-1){1'b0}}};
    end

    // Engine step
    logic [W:0]     msum, dsh;
    logic [W-1:0]   ddiff;
    logic           borrow;
    logic [2*W-1:0] mul_next, div_next;

    always_comb begin
        msum     = {1'b0, acc[2*W-1:W]} + (x_q[0] ? {1'b0, y_q} : '0);
        mul_next = {msum, acc[W-1:1]};
        dsh      = {acc[2*W-1:W], x_q[W-1]};
        borrow   = ~dsh[W] & (dsh[W-1:0] < y_q);
        ddiff    = dsh[W-1:0] - y_q;
        div_next = {(borrow ? dsh[W-1:0] : ddiff), acc[W-2:0], ~borrow};
    end

    logic [2*W-1:0] prod;
    logic [W-1:0]   quot, rem, sel;

    always_comb begin
        prod = neg_q ? -acc : acc;
        quot = neg_q ? -acc[W-1:0] : acc[W-1:0];
        rem  = neg_q ? -acc[2*W-1:W] : acc[2*W-1:W];
        case (op_q)
            3'b000:                 sel = prod[W-1:0];
            3'b001, 3'b010, 3'b011: sel = prod[2*W-1:W];
            3'b100, 3'b101:         sel = quot;
            default:                sel = rem;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = special ? FIXUP : CALC;
            CALC:    if (cnt == CW'(W - 1)) state_next = FIXUP;
            FIXUP:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q   <= '0;
            neg_q  <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            x_q    <= '0;
            y_q    <= '0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    op_q  <= op;
                    cnt   <= '0;
                    neg_q <= special ? 1'b0 : neg_in;
                    acc   <= special ? special_acc : '0;
                    x_q   <= is_div ? mag_a : mag_b;
                    y_q   <= is_div ? mag_b : mag_a;
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                    if (op_q[2]) begin
                        acc <= div_next;
                        x_q <= x_q << 1;
                    end else begin
                        acc <= mul_next;
                        x_q <= x_q >> 1;
                    end
                end
                FIXUP: begin
                    result <= sel;
                    done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed RV32M cases plus random
// operations checked against a 64-bit arithmetic reference model.
module tb_mul_div_unit;
    logic        clk = 1'b0;
    logic        rst, start;
    logic [2:0]  op;
    logic [31:0] src_a, src_b;
    logic        busy, done;
    logic [31:0] result;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    mul_div_unit #(.DATAWIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b),
        .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, p;
        logic [63:0] pu;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        case (f3)
            3'd0: begin p = ua * ub; pu = p; return pu[31:0]; end
            3'd1: begin p = sa * sb; pu = p; return pu[63:32]; end
            3'd2: begin p = sa * ub; pu = p; return pu[63:32]; end
            3'd3: begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb; pu = p; return pu[31:0];
            end
            3'd5: begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sb; pu = p; return pu[31:0];
            end
            default: begin if (b == 0) return a; return a % b; end
        endcase
    endfunction

    function automatic int exp_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2] && b == 0) return 2;
        if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
        return 34;
    endfunction

    // Entered #1 after a rising edge; start is driven in that cycle (cycle 0).
    // Returns #1 after the edge that raised done, so a following call starts
    // back-to-back in the done cycle.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input int repulse_at);
        int cyc, nbusy, lat;
        logic [31:0] exp;
        exp   = ref_model(f3, a, b);
        lat   = exp_latency(f3, a, b);
        start = 1'b1; op = f3; src_a = a; src_b = b;
        @(posedge clk); #1;
        start = 1'b0; op = 3'($urandom); src_a = $urandom; src_b = $urandom;
        cyc = 1; nbusy = 0;
        while (!done && cyc < 100) begin
            if (busy) nbusy++;
            start = (cyc == repulse_at);
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
        end
        check($sformatf("latency op%0d", f3), 32'(cyc), 32'(lat));
        check($sformatf("busy_cycles op%0d", f3), 32'(nbusy), 32'(lat - 1));
        check("busy_at_done", {31'b0, busy}, 32'h0);
        check($sformatf("result op%0d a=%08h b=%08h", f3, a, b), result, exp);
    endtask

    initial begin
        int cyc;
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        rst = 1'b1; start = 1'b0; op = '0; src_a = '0; src_b = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset busy", {31'b0, busy}, 32'h0);
        check("reset done", {31'b0, done}, 32'h0);
        check("reset result", result, 32'h0);

        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, -1);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, -1);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, -1);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, -1);
        run_op(3'd5, 32'd100, 32'd7, -1);
        run_op(3'd7, 32'd100, 32'd7, -1);
        run_op(3'd5, 32'd5, 32'd0, -1);
        run_op(3'd7, 32'd5, 32'd0, -1);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        run_op(3'd4, 32'd12345, 32'd0, -1);
        run_op(3'd6, 32'hDEAD_BEEF, 32'd0, -1);

        // Start re-pulsed in cycle 10 is ignored; next op starts in the done cycle
        run_op(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 10);
        run_op(3'd5, 32'hFFFF_0000, 32'd3, -1);

        // Reset in cycle 20 of a DIV aborts it
        start = 1'b1; op = 3'd4; src_a = 32'hF000_0001; src_b = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        for (cyc = 1; cyc < 20; cyc++) begin
            if (done) check("no done before abort", {31'b0, done}, 32'h0);
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort busy", {31'b0, busy}, 32'h0);
        check("abort done", {31'b0, done}, 32'h0);
        check("abort result", result, 32'h0);
        run_op(3'd6, 32'hF000_0001, 32'd5, -1);

        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 15))
                0, 1: rb = 32'h0;
                2:    begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                3, 4: rb = 32'($urandom_range(1, 20));
                5:    ra = 32'h8000_0000;
                default: ;
            endcase
            run_op(rop, ra, rb, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 30)) : -1);
        end

        @(posedge clk); #1;
        check("done single pulse", {31'b0, done}, 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
